// File: rtl/cpu_thread_pkg.sv
// Thread-count constants and types shared by the arbiter, the pipeline tid shift registers
// and the per-thread PC bank.
package cpu_thread_pkg;
    localparam int NTHREADS     = 4;
    localparam int TID_W        = 2;
    localparam int PC_W_DEFAULT = 9;

    typedef logic [TID_W-1:0]        tid_t;
    typedef logic [PC_W_DEFAULT-1:0] pc_t;

    function automatic logic [NTHREADS-1:0] tid_dec(input tid_t t);
        logic [NTHREADS-1:0] oh;
        oh    = '0;
        oh[t] = 1'b1;
        return oh;
    endfunction
endpackage

// File: rtl/thread_pc_bank_4way_if.sv
// Command/fetch bundle between the pipeline and the thread PC bank.
interface thread_pc_bank_4way_if
    import cpu_thread_pkg::*;
#(
    parameter int PC_W = PC_W_DEFAULT
);
    logic                en;
    tid_t                tid_in;
    logic                br_valid;
    tid_t                br_tid;
    logic [PC_W-1:0]     br_target;
    logic                start_valid;
    tid_t                start_tid;
    logic [PC_W-1:0]     start_pc;
    logic                halt_valid;
    tid_t                halt_tid;
    logic [PC_W-1:0]     fetch_pc;
    tid_t                fetch_tid;
    logic                fetch_valid;
    logic [NTHREADS-1:0] thread_active;

    modport master (
        output en, tid_in, br_valid, br_tid, br_target,
               start_valid, start_tid, start_pc, halt_valid, halt_tid,
        input  fetch_pc, fetch_tid, fetch_valid, thread_active
    );

    modport slave (
        input  en, tid_in, br_valid, br_tid, br_target,
               start_valid, start_tid, start_pc, halt_valid, halt_tid,
        output fetch_pc, fetch_tid, fetch_valid, thread_active
    );
endinterface

// File: rtl/thread_pc_slot.sv
// One thread's PC and active flag; priority start > halt > fetch increment > branch.
module thread_pc_slot #(
    parameter int              PC_W         = 9,
    parameter logic [PC_W-1:0] RESET_VAL    = '0,
    parameter bit              RESET_ACTIVE = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en_i,
    input  logic            fetch_i,
    input  logic [PC_W-1:0] fetch_pc_i,
    input  logic            br_i,
    input  logic [PC_W-1:0] br_target_i,
    input  logic            start_i,
    input  logic [PC_W-1:0] start_pc_i,
    input  logic            halt_i,
    output logic [PC_W-1:0] pc_o,
    output logic            active_o
);
    logic [PC_W-1:0] pc_q, pc_d;
    logic            active_q, active_d;

    // fetch_pc_i already carries the bypassed target when a same-tid branch coincides
    always_comb begin
        pc_d     = pc_q;
        active_d = active_q;
        if (start_i) begin
            pc_d     = start_pc_i;
            active_d = 1'b1;
        end else if (halt_i) begin
            active_d = 1'b0;
        end else if (fetch_i) begin
            pc_d = fetch_pc_i + PC_W'(1);
        end else if (br_i) begin
            pc_d = br_target_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q     <= RESET_VAL;
            active_q <= RESET_ACTIVE;
        end else if (en_i) begin
            pc_q     <= pc_d;
            active_q <= active_d;
        end
    end

    assign pc_o     = pc_q;
    assign active_o = active_q;
endmodule

// File: rtl/thread_pc_bank_4way.sv
// Per-thread PC bank for the 4-way barrel CPU: issues the arbiter-selected thread's PC to IMEM
// and applies branch redirects and start/halt commands from later stages.
module thread_pc_bank_4way
    import cpu_thread_pkg::*;
#(
    parameter int                  PC_W          = 9,
    parameter int                  RESET_PC      = 0,
    parameter int                  THREAD_STRIDE = 128,
    parameter logic [NTHREADS-1:0] ACTIVE_MASK   = 4'hF
) (
    input  logic                  clk,
    input  logic                  rst,
    thread_pc_bank_4way_if.slave  bus
);
    logic [PC_W-1:0]     slot_pc [NTHREADS];
    logic [NTHREADS-1:0] slot_active;
    logic [NTHREADS-1:0] fetch_dec, br_dec, start_dec, halt_dec;
    logic                br_hit, start_hit, issue;
    logic [PC_W-1:0]     fetch_p;

    logic [PC_W-1:0]     fetch_pc_q, fetch_pc_d;
    tid_t                fetch_tid_q, fetch_tid_d;
    logic                fetch_valid_q, fetch_valid_d;

    // A start aimed at the slot being fetched suppresses that slot's fetch
    always_comb begin
        br_hit    = bus.br_valid && (bus.br_tid == bus.tid_in);
        start_hit = bus.start_valid && (bus.start_tid == bus.tid_in);
        issue     = bus.en && slot_active[bus.tid_in] && !start_hit;
        fetch_p   = br_hit ? bus.br_target : slot_pc[bus.tid_in];
    end

    always_comb begin
        fetch_dec = issue           ? tid_dec(bus.tid_in)    : '0;
        br_dec    = bus.br_valid    ? tid_dec(bus.br_tid)    : '0;
        start_dec = bus.start_valid ? tid_dec(bus.start_tid) : '0;
        halt_dec  = bus.halt_valid  ? tid_dec(bus.halt_tid)  : '0;
    end

    for (genvar i = 0; i < NTHREADS; i++) begin : g_slot
        localparam logic [PC_W-1:0] SLOT_RESET_PC = PC_W'(RESET_PC + i * THREAD_STRIDE);

        thread_pc_slot #(
            .PC_W         (PC_W),
            .RESET_VAL    (SLOT_RESET_PC),
            .RESET_ACTIVE (ACTIVE_MASK[i])
        ) u_slot (
            .clk         (clk),
            .rst         (rst),
            .en_i        (bus.en),
            .fetch_i     (fetch_dec[i]),
            .fetch_pc_i  (fetch_p),
            .br_i        (br_dec[i]),
            .br_target_i (bus.br_target),
            .start_i     (start_dec[i]),
            .start_pc_i  (bus.start_pc),
            .halt_i      (halt_dec[i]),
            .pc_o        (slot_pc[i]),
            .active_o    (slot_active[i])
        );
    end

    // fetch_valid drops whenever no fetch issues, including while frozen by en
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        fetch_tid_d   = fetch_tid_q;
        fetch_valid_d = issue;
        if (bus.en) begin
            fetch_tid_d = bus.tid_in;
            if (issue) begin
                fetch_pc_d = fetch_p;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q    <= '0;
            fetch_tid_q   <= '0;
            fetch_valid_q <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            fetch_tid_q   <= fetch_tid_d;
            fetch_valid_q <= fetch_valid_d;
        end
    end

    assign bus.fetch_pc      = fetch_pc_q;
    assign bus.fetch_tid     = fetch_tid_q;
    assign bus.fetch_valid   = fetch_valid_q;
    assign bus.thread_active = slot_active;
endmodule

// File: tb/tb_thread_pc_bank_4way.sv
// Directed bench for thread_pc_bank_4way: reset sequence, branch, bypass, halt/start,
// wrap, enable freeze and asynchronous reset.
module tb_thread_pc_bank_4way;
    import cpu_thread_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    thread_pc_bank_4way_if #(.PC_W(9)) bus ();

    thread_pc_bank_4way #(
        .PC_W          (9),
        .RESET_PC      (0),
        .THREAD_STRIDE (128),
        .ACTIVE_MASK   (4'hF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_cmds();
        bus.br_valid    = 1'b0;
        bus.br_tid      = '0;
        bus.br_target   = '0;
        bus.start_valid = 1'b0;
        bus.start_tid   = '0;
        bus.start_pc    = '0;
        bus.halt_valid  = 1'b0;
        bus.halt_tid    = '0;
    endtask

    // Drive tid for one edge, then return 1 time unit after it
    task automatic cyc(input tid_t t);
        bus.tid_in = t;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst    = 1'b0;
        bus.en = 1'b1;
        clear_cmds();
        bus.tid_in = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.fetch_pc !== 9'h000) begin
            failures++;
            $display("FAIL reset_fetch_pc: got %h want 000", bus.fetch_pc);
        end
        checks++;
        if (bus.fetch_valid !== 1'b0 || bus.fetch_tid !== 2'd0) begin
            failures++;
            $display("FAIL reset_valid_tid: got valid=%b tid=%0d want valid=0 tid=0",
                     bus.fetch_valid, bus.fetch_tid);
        end
        checks++;
        if (bus.thread_active !== 4'hF) begin
            failures++;
            $display("FAIL reset_active: got %h want f", bus.thread_active);
        end
        rst = 1'b1;
    endtask

    task automatic test_sequence(input string tag);
        tid_t       tids [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [8:0] pcs  [5] = '{9'd0, 9'd128, 9'd256, 9'd384, 9'd1};
        for (int k = 0; k < 5; k++) begin
            cyc(tids[k]);
            checks++;
            if (bus.fetch_pc !== pcs[k] || bus.fetch_valid !== 1'b1 || bus.fetch_tid !== tids[k]) begin
                failures++;
                $display("FAIL %s[%0d]: got pc=%h v=%b tid=%0d want pc=%h v=1 tid=%0d",
                         tag, k, bus.fetch_pc, bus.fetch_valid, bus.fetch_tid, pcs[k], tids[k]);
            end
        end
    endtask

    task automatic test_branch();
        tid_t       tids [5] = '{2'd3, 2'd0, 2'd2, 2'd1, 2'd2};
        logic [8:0] pcs  [5] = '{9'h181, 9'h002, 9'h040, 9'h081, 9'h041};
        for (int k = 0; k < 5; k++) begin
            clear_cmds();
            if (k == 0) begin
                bus.br_valid  = 1'b1;
                bus.br_tid    = 2'd2;
                bus.br_target = 9'h040;
            end
            cyc(tids[k]);
            checks++;
            if (bus.fetch_pc !== pcs[k] || bus.fetch_valid !== 1'b1 || bus.fetch_tid !== tids[k]) begin
                failures++;
                $display("FAIL branch[%0d]: got pc=%h v=%b tid=%0d want pc=%h v=1 tid=%0d",
                         k, bus.fetch_pc, bus.fetch_valid, bus.fetch_tid, pcs[k], tids[k]);
            end
        end
        clear_cmds();
    endtask

    task automatic test_bypass();
        tid_t       tids [3] = '{2'd1, 2'd2, 2'd1};
        logic [8:0] pcs  [3] = '{9'h1F0, 9'h042, 9'h1F1};
        for (int k = 0; k < 3; k++) begin
            clear_cmds();
            if (k == 0) begin
                bus.br_valid  = 1'b1;
                bus.br_tid    = 2'd1;
                bus.br_target = 9'h1F0;
            end
            cyc(tids[k]);
            checks++;
            if (bus.fetch_pc !== pcs[k] || bus.fetch_valid !== 1'b1 || bus.fetch_tid !== tids[k]) begin
                failures++;
                $display("FAIL bypass[%0d]: got pc=%h v=%b tid=%0d want pc=%h v=1 tid=%0d",
                         k, bus.fetch_pc, bus.fetch_valid, bus.fetch_tid, pcs[k], tids[k]);
            end
        end
        clear_cmds();
    endtask

    task automatic test_halt_start();
        tid_t       tids [8] = '{2'd0, 2'd3, 2'd3, 2'd0, 2'd3, 2'd2, 2'd2, 2'd2};
        logic [8:0] pcs  [8] = '{9'h003, 9'h003, 9'h003, 9'h004, 9'h0AA, 9'h043, 9'h043, 9'h010};
        logic       vlds [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [3:0] acts [8] = '{4'h7, 4'h7, 4'h7, 4'hF, 4'hF, 4'hB, 4'hF, 4'hF};
        for (int k = 0; k < 8; k++) begin
            clear_cmds();
            case (k)
                0: begin bus.halt_valid = 1'b1; bus.halt_tid = 2'd3; end
                3: begin bus.start_valid = 1'b1; bus.start_tid = 2'd3; bus.start_pc = 9'h0AA; end
                5: begin bus.halt_valid = 1'b1; bus.halt_tid = 2'd2; end
                6: begin bus.start_valid = 1'b1; bus.start_tid = 2'd2; bus.start_pc = 9'h010; end
                default: ;
            endcase
            cyc(tids[k]);
            checks++;
            if (bus.fetch_pc !== pcs[k] || bus.fetch_valid !== vlds[k] || bus.fetch_tid !== tids[k]) begin
                failures++;
                $display("FAIL halt_start[%0d]: got pc=%h v=%b tid=%0d want pc=%h v=%b tid=%0d",
                         k, bus.fetch_pc, bus.fetch_valid, bus.fetch_tid, pcs[k], vlds[k], tids[k]);
            end
            checks++;
            if (bus.thread_active !== acts[k]) begin
                failures++;
                $display("FAIL halt_start_active[%0d]: got %h want %h", k, bus.thread_active, acts[k]);
            end
        end
        clear_cmds();
    endtask

    task automatic test_wrap_enable();
        tid_t       tids [9] = '{2'd1, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd0};
        logic       ens  [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [8:0] pcs  [9] = '{9'h1F2, 9'h1FF, 9'h000, 9'h000, 9'h000, 9'h000, 9'h1F3, 9'h011, 9'h001};
        tid_t       etid [9] = '{2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd0};
        for (int k = 0; k < 9; k++) begin
            clear_cmds();
            bus.en = ens[k];
            if (k == 0) begin
                bus.br_valid  = 1'b1;
                bus.br_tid    = 2'd0;
                bus.br_target = 9'h1FF;
            end else if (!ens[k]) begin
                bus.br_valid    = 1'b1;
                bus.br_tid      = 2'd1;
                bus.br_target   = 9'h055;
                bus.halt_valid  = 1'b1;
                bus.halt_tid    = 2'd1;
                bus.start_valid = 1'b1;
                bus.start_tid   = 2'd2;
                bus.start_pc    = 9'h077;
            end
            cyc(tids[k]);
            checks++;
            if (bus.fetch_pc !== pcs[k] || bus.fetch_valid !== ens[k] || bus.fetch_tid !== etid[k]) begin
                failures++;
                $display("FAIL wrap_en[%0d]: got pc=%h v=%b tid=%0d want pc=%h v=%b tid=%0d",
                         k, bus.fetch_pc, bus.fetch_valid, bus.fetch_tid, pcs[k], ens[k], etid[k]);
            end
            checks++;
            if (bus.thread_active !== 4'hF) begin
                failures++;
                $display("FAIL wrap_en_active[%0d]: got %h want f", k, bus.thread_active);
            end
        end
        clear_cmds();
        bus.en = 1'b1;
    endtask

    task automatic test_async_reset();
        cyc(2'd3);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.fetch_pc !== 9'h000 || bus.fetch_valid !== 1'b0 || bus.fetch_tid !== 2'd0) begin
            failures++;
            $display("FAIL async_reset_out: got pc=%h v=%b tid=%0d want pc=000 v=0 tid=0",
                     bus.fetch_pc, bus.fetch_valid, bus.fetch_tid);
        end
        checks++;
        if (bus.thread_active !== 4'hF) begin
            failures++;
            $display("FAIL async_reset_active: got %h want f", bus.thread_active);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        test_sequence("after_reset");
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_sequence("seq");
        test_branch();
        test_bypass();
        test_halt_start();
        test_wrap_enable();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
